// File: rtl/aurora_tx_packet_arbiter.sv
// Packet-atomic round-robin arbiter that shares one Aurora TX AXI-stream between NUM_SRC sources.
// It aborts a stalled packet with a trailer word and reports one status code per FA strobe.
module aurora_tx_packet_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                       auroraUserClk,
  input  logic                       auroraUserRst_n,
  input  logic                       auroraFAstrobe,
  input  logic [NUM_SRC-1:0]         srcEnable,
  input  logic [NUM_SRC*DW-1:0]      src_tdata,
  input  logic [NUM_SRC-1:0]         src_tvalid,
  input  logic [NUM_SRC-1:0]         src_tlast,
  output logic [NUM_SRC-1:0]         src_tready,
  output logic [DW-1:0]              m_tdata,
  output logic                       m_tvalid,
  output logic                       m_tlast,
  input  logic                       m_tready,
  output logic [$clog2(NUM_SRC)-1:0] grantIndex,
  output logic                       statusStrobe,
  output logic [1:0]                 statusCode
);

  localparam int GW = $clog2(NUM_SRC);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] LAST_SRC = GW'(NUM_SRC - 1);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_XFER  = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  state_t          state;
  state_t          stateNext;
  logic [GW-1:0]   rrPtr;
  logic [GW-1:0]   reqGrant;
  logic [NUM_SRC-1:0] reqVec;
  logic            reqAny;
  int              idx;
  logic [TW-1:0]   toCnt;
  logic            beat;
  logic            pktSeen;
  logic            timeoutSeen;
  logic [1:0]      codeNext;
  logic [DW-1:0]   abortWord;

  assign beat = m_tvalid & m_tready;

  // Round-robin search for the first requester at or above rrPtr, wrapping.
  always_comb begin
    reqVec   = src_tvalid & srcEnable;
    reqAny   = 1'b0;
    reqGrant = '0;
    idx      = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(rrPtr) + k;
      if (idx >= NUM_SRC) begin
        idx = idx - NUM_SRC;
      end else begin
        idx = idx;
      end
      if (!reqAny && reqVec[idx]) begin
        reqAny   = 1'b1;
        reqGrant = GW'(idx);
      end else begin
        reqAny   = reqAny;
      end
    end
  end

  // State register.
  always_ff @(posedge auroraUserClk or negedge auroraUserRst_n) begin
    if (!auroraUserRst_n) begin
      state <= ST_ARB;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic; abort only while the source is idle so a shown beat is never withdrawn.
  always_comb begin
    stateNext = state;
    case (state)
      ST_ARB: begin
        if (reqAny) stateNext = ST_XFER;
        else        stateNext = ST_ARB;
      end
      ST_XFER: begin
        if (beat && m_tlast)                                  stateNext = ST_ARB;
        else if (!src_tvalid[grantIndex] && toCnt == TO_LAST) stateNext = ST_ABORT;
        else                                                  stateNext = ST_XFER;
      end
      ST_ABORT: begin
        if (m_tready) stateNext = ST_ARB;
        else          stateNext = ST_ABORT;
      end
      default: stateNext = ST_ARB;
    endcase
  end

  // Grant pointer, grant index and stall counter.
  always_ff @(posedge auroraUserClk or negedge auroraUserRst_n) begin
    if (!auroraUserRst_n) begin
      rrPtr      <= '0;
      grantIndex <= '0;
      toCnt      <= '0;
    end else begin
      if (state == ST_ARB && reqAny) begin
        grantIndex <= reqGrant;
        rrPtr      <= (reqGrant == LAST_SRC) ? '0 : reqGrant + GW'(1);
      end else begin
        grantIndex <= grantIndex;
        rrPtr      <= rrPtr;
      end
      if (state == ST_XFER && !src_tvalid[grantIndex]) begin
        toCnt <= toCnt + TW'(1);
      end else begin
        toCnt <= '0;
      end
    end
  end

  // Trailer word: 16'hDEAD at the top, aborted source index at the bottom.
  always_comb begin
    abortWord              = '0;
    abortWord[DW-1 -: 16]  = 16'hDEAD;
    abortWord[GW-1:0]      = grantIndex;
  end

  // Stream outputs: zero-latency passthrough of the granted source, or the abort trailer.
  always_comb begin
    m_tdata    = '0;
    m_tvalid   = 1'b0;
    m_tlast    = 1'b0;
    src_tready = '0;
    case (state)
      ST_XFER: begin
        m_tdata                = src_tdata[grantIndex*DW +: DW];
        m_tvalid               = src_tvalid[grantIndex];
        m_tlast                = src_tlast[grantIndex];
        src_tready[grantIndex] = m_tready;
      end
      ST_ABORT: begin
        m_tdata  = abortWord;
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
      end
      default: begin
        m_tdata  = '0;
        m_tvalid = 1'b0;
      end
    endcase
  end

  // Status priority: in-flight packet beats timeout, timeout beats an empty interval.
  always_comb begin
    if (state != ST_ARB)  codeNext = 2'd3;
    else if (timeoutSeen) codeNext = 2'd2;
    else if (!pktSeen)    codeNext = 2'd1;
    else                  codeNext = 2'd0;
  end

  // Sticky interval flags and status report; events on the strobe cycle count for the new interval.
  always_ff @(posedge auroraUserClk or negedge auroraUserRst_n) begin
    if (!auroraUserRst_n) begin
      statusStrobe <= 1'b0;
      statusCode   <= 2'd0;
      pktSeen      <= 1'b0;
      timeoutSeen  <= 1'b0;
    end else begin
      statusStrobe <= auroraFAstrobe;
      if (auroraFAstrobe) statusCode <= codeNext;
      else                statusCode <= statusCode;
      if (state == ST_XFER && beat && m_tlast) pktSeen <= 1'b1;
      else if (auroraFAstrobe)                 pktSeen <= 1'b0;
      else                                     pktSeen <= pktSeen;
      if (state == ST_ABORT && m_tready) timeoutSeen <= 1'b1;
      else if (auroraFAstrobe)           timeoutSeen <= 1'b0;
      else                               timeoutSeen <= timeoutSeen;
    end
  end

endmodule

// File: tb/tb_aurora_tx_packet_arbiter.sv
// Directed bench for aurora_tx_packet_arbiter: NUM_SRC=2, DW=32, TIMEOUT=8.
module tb_aurora_tx_packet_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        strobe = 1'b0;
  logic [1:0]  en = 2'b11;
  logic [63:0] sdata = '0;
  logic [1:0]  svalid = '0;
  logic [1:0]  slast = '0;
  logic [1:0]  sready;
  logic [31:0] mdata;
  logic        mvalid, mlast;
  logic        mready = 1'b1;
  logic [0:0]  gidx;
  logic        stStr;
  logic [1:0]  stCode;

  int nTests = 0;
  int nFail  = 0;

  int          srcAuto[2], srcLen[2], srcCnt[2], srcPkt[2], srcNpk[2];
  logic [31:0] srcBase[2];
  logic [31:0] obsData[64];
  logic        obsLast[64];
  logic [0:0]  obsGrant[64];
  int          obsCount = 0;

  aurora_tx_packet_arbiter #(.NUM_SRC(2), .DW(32), .TIMEOUT(TO)) dut (
    .auroraUserClk(clk), .auroraUserRst_n(rst_n), .auroraFAstrobe(strobe),
    .srcEnable(en), .src_tdata(sdata), .src_tvalid(svalid), .src_tlast(slast),
    .src_tready(sready), .m_tdata(mdata), .m_tvalid(mvalid), .m_tlast(mlast),
    .m_tready(mready), .grantIndex(gidx), .statusStrobe(stStr), .statusCode(stCode)
  );

  always #5 clk = ~clk;

  task automatic drive_src(input int s);
    if (srcAuto[s] != 0) begin
      svalid[s]         = 1'b1;
      sdata[s*32 +: 32] = srcBase[s] + 32'(srcPkt[s]*16 + srcCnt[s]);
      slast[s]          = (srcCnt[s] == srcLen[s]-1);
    end else begin
      svalid[s] = 1'b0;
      slast[s]  = 1'b0;
    end
  endtask

  task automatic start_src(input int s, input logic [31:0] base, input int len, input int npk);
    srcAuto[s] = 1; srcBase[s] = base; srcLen[s] = len;
    srcCnt[s] = 0; srcPkt[s] = 0; srcNpk[s] = npk;
    drive_src(s);
  endtask

  // One clock: log the output beat, then advance any source whose beat was accepted.
  task automatic cycle();
    logic [1:0] fired;
    #1;
    fired = svalid & sready;
    if (mvalid && mready && obsCount < 64) begin
      obsData[obsCount] = mdata; obsLast[obsCount] = mlast; obsGrant[obsCount] = gidx;
      obsCount++;
    end
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      if (fired[s] && srcAuto[s] != 0) begin
        if (srcCnt[s] == srcLen[s]-1) begin
          srcCnt[s] = 0; srcPkt[s]++;
          if (srcPkt[s] == srcNpk[s]) srcAuto[s] = 0;
        end else begin
          srcCnt[s]++;
        end
        drive_src(s);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    nTests++;
    if ({mvalid, mlast, mdata, sready, gidx, stStr, stCode} !== 40'd0) begin
      nFail++;
      $display("FAIL reset_outputs got v=%b l=%b d=%h rdy=%b g=%0d ss=%b sc=%0d want all 0",
               mvalid, mlast, mdata, sready, gidx, stStr, stCode);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_strobe_idle();
    strobe = 1'b1; cycle(); strobe = 1'b0;
    nTests++;
    if (stStr !== 1'b1 || stCode !== 2'd1) begin
      nFail++; $display("FAIL strobe_idle got ss=%b code=%0d want ss=1 code=1", stStr, stCode);
    end
    cycle();
    nTests++;
    if (stStr !== 1'b0) begin
      nFail++; $display("FAIL strobe_pulse_width got ss=%b want 0", stStr);
    end
  endtask

  task automatic test_single();
    int n = 0;
    logic bad = 1'b0;
    obsCount = 0;
    start_src(0, 32'h1000_0000, 4, 1);
    #1;
    nTests++;
    if (mvalid !== 1'b0) begin
      nFail++; $display("FAIL single_arb_idle got m_tvalid=%b want 0", mvalid);
    end
    while (obsCount < 4 && n < 20) begin
      cycle(); n++;
      if (sready[1] !== 1'b0) bad = 1'b1;
    end
    nTests++;
    if (obsCount != 4 || bad) begin
      nFail++; $display("FAIL single_count got beats=%0d rdy1_seen=%b want 4 and 0", obsCount, bad);
    end
    for (int i = 0; i < 4; i++) begin
      nTests++;
      if (obsData[i] !== 32'h1000_0000 + 32'(i) || obsLast[i] !== (i == 3) || obsGrant[i] !== 1'b0) begin
        nFail++; $display("FAIL single_beat%0d got d=%h l=%b g=%0d want d=%h l=%b g=0",
                          i, obsData[i], obsLast[i], obsGrant[i], 32'h1000_0000 + 32'(i), (i == 3));
      end
    end
  endtask

  task automatic test_alternate();
    int n = 0;
    int order[4] = '{1, 0, 1, 0};
    int pkt[4]   = '{0, 0, 1, 1};
    logic [31:0] base[2] = '{32'hA000_0000, 32'hB000_0000};
    logic [31:0] exp;
    obsCount = 0;
    start_src(0, base[0], 3, 2);
    start_src(1, base[1], 3, 2);
    while (obsCount < 12 && n < 60) begin cycle(); n++; end
    nTests++;
    if (obsCount != 12) begin
      nFail++; $display("FAIL alt_count got %0d beats want 12", obsCount);
    end
    for (int i = 0; i < 12; i++) begin
      exp = base[order[i/3]] + 32'(pkt[i/3]*16 + i%3);
      nTests++;
      if (obsData[i] !== exp || obsLast[i] !== (i%3 == 2) || obsGrant[i] !== 1'(order[i/3])) begin
        nFail++; $display("FAIL alt_beat%0d got d=%h l=%b g=%0d want d=%h l=%b g=%0d",
                          i, obsData[i], obsLast[i], obsGrant[i], exp, (i%3 == 2), order[i/3]);
      end
    end
  endtask

  task automatic test_tready_toggle();
    int n = 0;
    logic prevStall = 1'b0;
    logic [31:0] prevData = '0;
    obsCount = 0;
    start_src(0, 32'hC000_0000, 5, 1);
    while (obsCount < 5 && n < 40) begin
      mready = n[0] ? 1'b0 : 1'b1;
      #1;
      if (prevStall && mvalid) begin
        nTests++;
        if (mdata !== prevData) begin
          nFail++; $display("FAIL tready_hold got d=%h want %h", mdata, prevData);
        end
      end
      prevStall = mvalid & ~mready;
      prevData  = mdata;
      cycle(); n++;
    end
    mready = 1'b1;
    nTests++;
    if (obsCount != 5) begin
      nFail++; $display("FAIL tready_count got %0d beats want 5", obsCount);
    end
    for (int i = 0; i < 5; i++) begin
      nTests++;
      if (obsData[i] !== 32'hC000_0000 + 32'(i) || obsLast[i] !== (i == 4)) begin
        nFail++; $display("FAIL tready_beat%0d got d=%h l=%b want d=%h l=%b",
                          i, obsData[i], obsLast[i], 32'hC000_0000 + 32'(i), (i == 4));
      end
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int idle = 0;
    obsCount = 0;
    svalid[0] = 1'b1; sdata[31:0] = 32'h5555_0000; slast[0] = 1'b0;
    while (obsCount < 1 && n < 10) begin cycle(); n++; end
    svalid[0] = 1'b0;
    for (int k = 0; k < TO + 4; k++) begin
      #1;
      if (mvalid) break;
      idle++;
      cycle();
    end
    nTests++;
    if (idle != TO) begin
      nFail++; $display("FAIL timeout_idle got %0d idle cycles want %0d", idle, TO);
    end
    nTests++;
    if (mvalid !== 1'b1 || mlast !== 1'b1 || mdata !== 32'hDEAD_0000 || sready !== 2'b00) begin
      nFail++; $display("FAIL timeout_trailer got v=%b l=%b d=%h rdy=%b want v=1 l=1 d=dead0000 rdy=00",
                        mvalid, mlast, mdata, sready);
    end
    mready = 1'b0; cycle();
    nTests++;
    if (mvalid !== 1'b1 || mdata !== 32'hDEAD_0000) begin
      nFail++; $display("FAIL timeout_hold got v=%b d=%h want v=1 d=dead0000", mvalid, mdata);
    end
    mready = 1'b1; cycle();
    nTests++;
    if (mvalid !== 1'b0) begin
      nFail++; $display("FAIL timeout_release got v=%b want 0", mvalid);
    end
    strobe = 1'b1; cycle(); strobe = 1'b0;
    nTests++;
    if (stStr !== 1'b1 || stCode !== 2'd2) begin
      nFail++; $display("FAIL timeout_code got ss=%b code=%0d want ss=1 code=2", stStr, stCode);
    end
  endtask

  task automatic test_strobe_midpacket();
    int n = 0;
    obsCount = 0;
    start_src(1, 32'hE000_0000, 4, 1);
    while (obsCount < 1 && n < 10) begin cycle(); n++; end
    strobe = 1'b1; cycle(); strobe = 1'b0;
    nTests++;
    if (stStr !== 1'b1 || stCode !== 2'd3) begin
      nFail++; $display("FAIL mid_code got ss=%b code=%0d want ss=1 code=3", stStr, stCode);
    end
    n = 0;
    while (obsCount < 4 && n < 20) begin cycle(); n++; end
    for (int i = 0; i < 4; i++) begin
      nTests++;
      if (obsData[i] !== 32'hE000_0000 + 32'(i) || obsLast[i] !== (i == 3) || obsGrant[i] !== 1'b1) begin
        nFail++; $display("FAIL mid_beat%0d got d=%h l=%b g=%0d want d=%h l=%b g=1",
                          i, obsData[i], obsLast[i], obsGrant[i], 32'hE000_0000 + 32'(i), (i == 3));
      end
    end
    cycle();
    strobe = 1'b1; cycle(); strobe = 1'b0;
    nTests++;
    if (stStr !== 1'b1 || stCode !== 2'd0) begin
      nFail++; $display("FAIL ok_code got ss=%b code=%0d want ss=1 code=0", stStr, stCode);
    end
  endtask

  task automatic test_reset_midpacket();
    int n = 0;
    obsCount = 0;
    start_src(0, 32'h7000_0000, 4, 1);
    while (obsCount < 2 && n < 10) begin cycle(); n++; end
    #2;
    rst_n = 1'b0;
    #1;
    nTests++;
    if (mvalid !== 1'b0 || sready !== 2'b00) begin
      nFail++; $display("FAIL rst_mid got v=%b rdy=%b want v=0 rdy=00", mvalid, sready);
    end
    @(posedge clk); #1;
    obsCount = 0;
    start_src(0, 32'h7100_0000, 1, 1);
    start_src(1, 32'h8100_0000, 1, 1);
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    while (obsCount < 1 && n < 10) begin cycle(); n++; end
    nTests++;
    if (obsCount < 1 || obsGrant[0] !== 1'b0 || obsData[0] !== 32'h7100_0000) begin
      nFail++; $display("FAIL rst_first_grant got n=%0d g=%0d d=%h want g=0 d=71000000",
                        obsCount, obsGrant[0], obsData[0]);
    end
    n = 0;
    while (obsCount < 2 && n < 10) begin cycle(); n++; end
  endtask

  initial begin
    srcAuto = '{0, 0};
    test_reset();
    test_strobe_idle();
    test_single();
    test_alternate();
    test_tready_toggle();
    test_timeout();
    test_strobe_midpacket();
    test_reset_midpacket();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
